// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin sharing of one toggle-handshake flash reader between two ports,
// with a sticky watchdog for a flash controller that never acknowledges.
module flash_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ireq0,
  input  logic [22:0] iaddr0,
  output logic        oack0,
  output logic [15:0] odata0,
  input  logic        ireq1,
  input  logic [22:0] iaddr1,
  output logic        oack1,
  output logic [15:0] odata1,
  output logic [22:0] ofl_addr,
  output logic        ofl_req,
  input  logic        ifl_ack,
  input  logic [15:0] ifl_data,
  output logic        obusy,
  output logic        ogrant,
  output logic        otimeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [15:0] wdog, wdog_next;
  logic pend0, pend1, sel;
  assign pend0 = ireq0 ^ oack0;
  assign pend1 = ireq1 ^ oack1;
  // on a tie the port not granted last time wins
  assign sel = (pend0 && pend1) ? ~ogrant : pend1;
  assign wdog_next = (wdog == 16'hffff) ? wdog : wdog + 16'd1;
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state <= IDLE;
      wdog <= '0;
      oack0 <= 1'b0;
      oack1 <= 1'b0;
      odata0 <= '0;
      odata1 <= '0;
      ofl_addr <= '0;
      ofl_req <= 1'b0;
      obusy <= 1'b0;
      ogrant <= 1'b1;
      otimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pend0 || pend1) begin
          ogrant <= sel;
          ofl_addr <= sel ? iaddr1 : iaddr0;
          obusy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          ofl_req <= ~ifl_ack;
          wdog <= '0;
          state <= WAIT;
        end
        WAIT: if (ofl_req == ifl_ack) begin
          if (ogrant) begin
            odata1 <= ifl_data;
            oack1 <= ~oack1;
          end else begin
            odata0 <= ifl_data;
            oack0 <= ~oack0;
          end
          obusy <= 1'b0;
          state <= IDLE;
        end else begin
          wdog <= wdog_next;
          if (TIMEOUT != 0 && int'(wdog_next) >= TIMEOUT) otimeout <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed and random checks of flash_arbiter against a flash model,
// with per-port scoreboards of expected read data.
module tb_flash_arbiter;
  logic iclk = 0, ireset = 1;
  logic ireq0 = 0, ireq1 = 0, oack0, oack1;
  logic [22:0] iaddr0 = '0, iaddr1 = '0, ofl_addr;
  logic [15:0] odata0, odata1, ifl_data = '0;
  logic ofl_req, ifl_ack = 0, obusy, ogrant, otimeout;
  int errors = 0, checks = 0;
  int acks0 = 0, acks1 = 0, reqs0 = 0, reqs1 = 0;
  int fl_lat = 2, lcnt = -1;
  bit fl_hold = 0;
  logic [15:0] q0[$], q1[$];
  logic gq[$];

  flash_arbiter #(.TIMEOUT(16)) dut (
    .iclk(iclk), .ireset(ireset),
    .ireq0(ireq0), .iaddr0(iaddr0), .oack0(oack0), .odata0(odata0),
    .ireq1(ireq1), .iaddr1(iaddr1), .oack1(oack1), .odata1(odata1),
    .ofl_addr(ofl_addr), .ofl_req(ofl_req), .ifl_ack(ifl_ack), .ifl_data(ifl_data),
    .obusy(obusy), .ogrant(ogrant), .otimeout(otimeout)
  );

  always #5 iclk = ~iclk;

  function automatic logic [15:0] fdata(input logic [22:0] a);
    return a[15:0] ^ 16'hA45A ^ {9'd0, a[22:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound(input string tag, input int n, input int budget);
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, budget);
    end
  endtask

  task automatic check_grant(input string tag, input logic exp);
    logic g;
    g = gq.size() != 0 ? gq.pop_front() : 1'bx;
    check(tag, {31'd0, g}, {31'd0, exp});
  endtask

  // call at a negedge; waits for the port to go quiet, then toggles a request
  task automatic issue(input bit p, input logic [22:0] a);
    int n = 0;
    while ((p ? ireq1 !== oack1 : ireq0 !== oack0) && n < 500) begin
      @(negedge iclk);
      n++;
    end
    bound("issue_wait", n, 500);
    if (p) begin
      iaddr1 = a;
      ireq1 = ~ireq1;
      q1.push_back(fdata(a));
      reqs1++;
    end else begin
      iaddr0 = a;
      ireq0 = ~ireq0;
      q0.push_back(fdata(a));
      reqs0++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || obusy || ireq0 !== oack0 || ireq1 !== oack1) && n < budget) begin
      @(negedge iclk);
      n++;
    end
    bound("idle_wait", n, budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oack0"}, {31'd0, oack0}, 0);
    check({tag, "_oack1"}, {31'd0, oack1}, 0);
    check({tag, "_odata0"}, {16'd0, odata0}, 0);
    check({tag, "_odata1"}, {16'd0, odata1}, 0);
    check({tag, "_ofl_addr"}, {9'd0, ofl_addr}, 0);
    check({tag, "_ofl_req"}, {31'd0, ofl_req}, 0);
    check({tag, "_obusy"}, {31'd0, obusy}, 0);
    check({tag, "_ogrant"}, {31'd0, ogrant}, 1);
    check({tag, "_otimeout"}, {31'd0, otimeout}, 0);
  endtask

  // flash controller model: acks a toggled request after fl_lat cycles (random when negative)
  initial forever begin
    @(posedge iclk);
    #1;
    if (ireset) begin
      ifl_ack = 0;
      lcnt = -1;
    end else if (ofl_req !== ifl_ack && !fl_hold) begin
      if (lcnt < 0) lcnt = fl_lat >= 0 ? fl_lat : int'($urandom_range(0, 4));
      if (lcnt == 0) begin
        ifl_data = fdata(ofl_addr);
        ifl_ack = ~ifl_ack;
        lcnt = -1;
      end else lcnt--;
    end
  end

  // monitor: every ack toggle pops that port's scoreboard; every new transaction logs its grant
  initial begin
    logic pa0, pa1, pb;
    logic [15:0] exp;
    pa0 = 0; pa1 = 0; pb = 0;
    forever begin
      @(posedge iclk);
      #1;
      if (ireset) begin
        pa0 = 0; pa1 = 0; pb = 0;
      end else begin
        if (oack0 !== pa0) begin
          acks0++;
          exp = q0.size() != 0 ? q0.pop_front() : 16'hxxxx;
          check("data0", {16'd0, odata0}, {16'd0, exp});
        end
        if (oack1 !== pa1) begin
          acks1++;
          exp = q1.size() != 0 ? q1.pop_front() : 16'hxxxx;
          check("data1", {16'd0, odata1}, {16'd0, exp});
        end
        if (obusy && !pb) gq.push_back(ogrant);
        pa0 = oack0; pa1 = oack1; pb = obusy;
      end
    end
  end

  initial begin
    logic sa1, sr;
    logic [15:0] sd1;
    logic [22:0] a;
    int n, n0, n1, guard;
    repeat (3) @(negedge iclk);
    check_reset_outputs("rst");
    ireset = 0;
    @(negedge iclk);
    // simultaneous requests right after reset: port 0 first
    issue(0, 23'h10);
    issue(1, 23'h20);
    wait_idle(200);
    check_grant("tie_first", 0);
    check_grant("tie_second", 1);
    check("tie_data1", {16'd0, odata1}, {16'd0, fdata(23'h20)});
    // single port 0 read
    sa1 = oack1; sd1 = odata1; sr = ofl_req;
    issue(0, 23'h000100);
    wait_idle(200);
    check_grant("single_grant", 0);
    check("single_addr", {9'd0, ofl_addr}, 32'h100);
    check("single_req", {31'd0, ofl_req}, {31'd0, ~sr});
    check("single_data0", {16'd0, odata0}, 32'hA55A);
    check("single_ack0", {31'd0, oack0}, {31'd0, ireq0});
    check("single_ack1", {31'd0, oack1}, {31'd0, sa1});
    check("single_data1", {16'd0, odata1}, {16'd0, sd1});
    // port 0 hammers while port 1 stays pending: grants alternate
    gq.delete();
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < 4 || n1 < 4) && guard < 400) begin
      if (n0 < 4 && ireq0 === oack0) begin
        issue(0, 23'(32'h200 + n0 * 2));
        n0++;
      end
      if (guard > 0 && n1 < 4 && ireq1 === oack1) begin
        issue(1, 23'(32'h300 + n1 * 2));
        n1++;
      end
      @(negedge iclk);
      guard++;
    end
    bound("rr_loop", guard, 400);
    wait_idle(200);
    for (int i = 0; i < 8; i++) check_grant($sformatf("rr_grant%0d", i), 1'(i % 2));
    // watchdog: flash never acks
    fl_hold = 1;
    issue(1, 23'h3000);
    n = 0;
    while (ofl_req === ifl_ack && n < 50) begin
      @(negedge iclk);
      n++;
    end
    bound("wd_issue", n, 50);
    repeat (15) @(negedge iclk);
    check("wd_before", {31'd0, otimeout}, 0);
    @(negedge iclk);
    check("wd_at", {31'd0, otimeout}, 1);
    repeat (5) @(negedge iclk);
    check("wd_sticky", {31'd0, otimeout}, 1);
    check("wd_busy", {31'd0, obusy}, 1);
    fl_hold = 0;
    wait_idle(200);
    check("wd_after", {31'd0, otimeout}, 1);
    check("wd_ack1", {31'd0, oack1}, {31'd0, ireq1});
    // reset during WAIT
    fl_hold = 1;
    issue(0, 23'h400);
    n = 0;
    while (ofl_req === ifl_ack && n < 50) begin
      @(negedge iclk);
      n++;
    end
    bound("mid_issue", n, 50);
    @(negedge iclk);
    ireset = 1;
    @(negedge iclk);
    check_reset_outputs("mid");
    ireset = 0; ireq0 = 0; ireq1 = 0; fl_hold = 0;
    q0.delete(); q1.delete(); gq.delete();
    acks0 = 0; acks1 = 0; reqs0 = 0; reqs1 = 0;
    @(negedge iclk);
    issue(0, 23'h402);
    wait_idle(200);
    check("post_acks0", acks0, 1);
    check("post_acks1", acks1, 0);
    check("post_data0", {16'd0, odata0}, {16'd0, fdata(23'h402)});
    // random back-to-back traffic with random flash latency
    fl_lat = -1;
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < 1000 || n1 < 1000) && guard < 40000) begin
      if (n0 < 1000 && ireq0 === oack0 && $urandom_range(0, 3) != 0) begin
        a = 23'($urandom) & ~23'd1;
        issue(0, a);
        n0++;
      end
      if (n1 < 1000 && ireq1 === oack1 && $urandom_range(0, 3) != 0) begin
        a = 23'($urandom) & ~23'd1;
        issue(1, a);
        n1++;
      end
      @(negedge iclk);
      guard++;
    end
    bound("rand_loop", guard, 40000);
    wait_idle(200);
    check("rand_acks0", acks0, reqs0);
    check("rand_acks1", acks1, reqs1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
